// File: rtl/key_debounce_fsm_pkg.sv
// Shared definitions for the board push-button conditioners: state encodings,
// default 50 MHz timing constants and the registered output bundle.
package key_debounce_fsm_pkg;

    localparam logic [1:0] ST_IDLE         = 2'd0;
    localparam logic [1:0] ST_PRESS_WAIT   = 2'd1;
    localparam logic [1:0] ST_PRESSED      = 2'd2;
    localparam logic [1:0] ST_RELEASE_WAIT = 2'd3;

    localparam int unsigned DEF_DEBOUNCE_CYCLES = 32'd500000;
    localparam int unsigned DEF_REPEAT_DELAY    = 32'd25000000;
    localparam int unsigned DEF_REPEAT_PERIOD   = 32'd5000000;

    typedef struct packed {
        logic key_lvl;
        logic press;
        logic rls;
        logic rpt;
        logic evt;
    } kd_out_t;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/key_debounce_fsm_sync_2ff.sv
// Two-flop synchroniser for a single asynchronous input; clears to 0 on reset.
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    // Metastability filter: two back-to-back capture flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/key_debounce_fsm.sv
// Push-button conditioner: synchronise, qualify with a stable-time FSM and emit
// a clean level plus registered press/release/auto-repeat strobes.
module key_debounce_fsm
    import key_debounce_fsm_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int unsigned KEY_ACTIVE_LOW  = 32'd0,
    parameter int unsigned REPEAT_EN       = 32'd0,
    parameter int unsigned REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int unsigned REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
    input  logic clk,
    input  logic reset_n,
    input  logic key_i,
    output logic key_o,
    output logic press_pulse,
    output logic release_pulse,
    output logic repeat_pulse,
    output logic key_event
);

    localparam int CNT_W  = $clog2(DEBOUNCE_CYCLES + 32'd1);
    localparam int RCNT_W = $clog2(max_u(REPEAT_DELAY, REPEAT_PERIOD) + 32'd1);

    localparam logic [CNT_W-1:0]  CNT_LAST   = CNT_W'(DEBOUNCE_CYCLES - 32'd1);
    localparam logic [CNT_W-1:0]  CNT_MAX    = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [RCNT_W-1:0] RPT_DELAY  = RCNT_W'(REPEAT_DELAY);
    localparam logic [RCNT_W-1:0] RPT_PERIOD = RCNT_W'(REPEAT_PERIOD);
    localparam logic              KEY_POL    = (KEY_ACTIVE_LOW != 32'd0) ? 1'b1 : 1'b0;
    localparam logic              RPT_ON     = (REPEAT_EN != 32'd0) ? 1'b1 : 1'b0;

    logic              w_sync;
    logic              w_key_s;
    logic [1:0]        r_state;
    logic [1:0]        w_state_next;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  w_cnt_next;
    logic [CNT_W-1:0]  w_cnt_inc;
    logic [RCNT_W-1:0] r_rcnt;
    logic [RCNT_W-1:0] w_rcnt_next;
    logic [RCNT_W-1:0] w_rcnt_inc;
    logic [RCNT_W-1:0] w_rpt_target;
    logic              r_rpt_first;
    logic              w_rpt_first_next;
    logic              w_press;
    logic              w_release;
    logic              w_repeat;
    kd_out_t           w_out_next;
    kd_out_t           r_out;

    sync_2ff u_sync (
        .clk   (clk),
        .rst_n (reset_n),
        .i_d   (key_i),
        .o_q   (w_sync)
    );

    assign w_key_s      = w_sync ^ KEY_POL;
    assign w_cnt_inc    = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + CNT_W'(1);
    // After the first strobe the repeat timer measures the shorter period.
    assign w_rpt_target = r_rpt_first ? RPT_PERIOD : RPT_DELAY;
    assign w_rcnt_inc   = (r_rcnt >= w_rpt_target) ? w_rpt_target : r_rcnt + RCNT_W'(1);

    // Next-state, counter and strobe decode.
    always_comb begin
        w_state_next     = r_state;
        w_cnt_next       = r_cnt;
        w_rcnt_next      = r_rcnt;
        w_rpt_first_next = r_rpt_first;
        w_press          = 1'b0;
        w_release        = 1'b0;
        w_repeat         = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_cnt_next       = '0;
                w_rcnt_next      = '0;
                w_rpt_first_next = 1'b0;
                if (w_key_s) begin
                    w_state_next = ST_PRESS_WAIT;
                end else begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_PRESS_WAIT: begin
                if (!w_key_s) begin
                    w_state_next = ST_IDLE;
                    w_cnt_next   = '0;
                end else if (r_cnt == CNT_LAST) begin
                    w_state_next     = ST_PRESSED;
                    w_cnt_next       = '0;
                    w_rcnt_next      = '0;
                    w_rpt_first_next = 1'b0;
                    w_press          = 1'b1;
                end else begin
                    w_cnt_next = w_cnt_inc;
                end
            end
            ST_PRESSED: begin
                w_cnt_next = '0;
                if (!w_key_s) begin
                    w_state_next = ST_RELEASE_WAIT;
                    w_rcnt_next  = w_rcnt_inc;
                end else if (RPT_ON && (w_rcnt_inc == w_rpt_target)) begin
                    w_repeat         = 1'b1;
                    w_rcnt_next      = '0;
                    w_rpt_first_next = 1'b1;
                end else begin
                    w_rcnt_next = w_rcnt_inc;
                end
            end
            ST_RELEASE_WAIT: begin
                // Timer keeps running (saturated) so a bounce does not restart repeat.
                if (w_key_s) begin
                    w_state_next = ST_PRESSED;
                    w_cnt_next   = '0;
                    w_rcnt_next  = w_rcnt_inc;
                end else if (r_cnt == CNT_LAST) begin
                    w_state_next = ST_IDLE;
                    w_cnt_next   = '0;
                    w_rcnt_next  = '0;
                    w_release    = 1'b1;
                end else begin
                    w_cnt_next  = w_cnt_inc;
                    w_rcnt_next = w_rcnt_inc;
                end
            end
            default: begin
                w_state_next     = ST_IDLE;
                w_cnt_next       = '0;
                w_rcnt_next      = '0;
                w_rpt_first_next = 1'b0;
            end
        endcase
    end

    // Output bundle derived from the next state so level and strobes align.
    always_comb begin
        w_out_next.key_lvl = (w_state_next == ST_PRESSED) || (w_state_next == ST_RELEASE_WAIT);
        w_out_next.press   = w_press;
        w_out_next.rls     = w_release;
        w_out_next.rpt     = w_repeat;
        w_out_next.evt     = w_press | w_repeat;
    end

    // State, timers and registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_rcnt      <= '0;
            r_rpt_first <= 1'b0;
            r_out       <= '0;
        end else begin
            r_state     <= w_state_next;
            r_cnt       <= w_cnt_next;
            r_rcnt      <= w_rcnt_next;
            r_rpt_first <= w_rpt_first_next;
            r_out       <= w_out_next;
        end
    end

    assign key_o         = r_out.key_lvl;
    assign press_pulse   = r_out.press;
    assign release_pulse = r_out.rls;
    assign repeat_pulse  = r_out.rpt;
    assign key_event     = r_out.evt;

endmodule

// File: tb/tb_key_debounce_fsm.sv
// Directed bench: cycle tables for press/bounce/release, hand sequences for
// auto-repeat, asynchronous reset and the active-low variant.
module tb_key_debounce_fsm;

    logic clk = 1'b0;
    logic reset_n;
    logic key;
    logic key_al;

    logic a_key_o, a_press, a_release, a_repeat, a_event;
    logic b_key_o, b_press, b_release, b_repeat, b_event;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic       key;
        logic [4:0] exp;
    } vec_t;

    vec_t vecs[$];

    always #5 clk = ~clk;

    key_debounce_fsm #(
        .DEBOUNCE_CYCLES (4),
        .KEY_ACTIVE_LOW  (0),
        .REPEAT_EN       (1),
        .REPEAT_DELAY    (10),
        .REPEAT_PERIOD   (3)
    ) dut_a (
        .clk           (clk),
        .reset_n       (reset_n),
        .key_i         (key),
        .key_o         (a_key_o),
        .press_pulse   (a_press),
        .release_pulse (a_release),
        .repeat_pulse  (a_repeat),
        .key_event     (a_event)
    );

    key_debounce_fsm #(
        .DEBOUNCE_CYCLES (4),
        .KEY_ACTIVE_LOW  (1),
        .REPEAT_EN       (0),
        .REPEAT_DELAY    (10),
        .REPEAT_PERIOD   (3)
    ) dut_b (
        .clk           (clk),
        .reset_n       (reset_n),
        .key_i         (key_al),
        .key_o         (b_key_o),
        .press_pulse   (b_press),
        .release_pulse (b_release),
        .repeat_pulse  (b_repeat),
        .key_event     (b_event)
    );

    function automatic logic [4:0] pack_a();
        return {a_key_o, a_press, a_release, a_repeat, a_event};
    endfunction

    function automatic logic [4:0] pack_b();
        return {b_key_o, b_press, b_release, b_repeat, b_event};
    endfunction

    task automatic check(input string name, input logic [4:0] act, input logic [4:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b (key_o,press,release,repeat,event)", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic push(input logic k, input int n, input logic ko, input logic p,
                        input logic r, input logic rp);
        for (int i = 0; i < n; i++) begin
            vecs.push_back('{k, {ko, p, r, rp, p | rp}});
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        logic exp_rp;

        reset_n = 1'b0;
        key     = 1'b0;
        key_al  = 1'b1;
        #3;
        check("reset_a", pack_a(), 5'b00000);
        check("reset_b", pack_b(), 5'b00000);
        repeat (3) @(posedge clk);
        @(negedge clk) reset_n = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        check("idle_a", pack_a(), 5'b00000);
        check("idle_b", pack_b(), 5'b00000);

        // Clean press then clean release.
        push(1'b1, 6, 1'b0, 1'b0, 1'b0, 1'b0);
        push(1'b1, 1, 1'b1, 1'b1, 1'b0, 1'b0);
        push(1'b1, 3, 1'b1, 1'b0, 1'b0, 1'b0);
        push(1'b0, 6, 1'b1, 1'b0, 1'b0, 1'b0);
        push(1'b0, 1, 1'b0, 1'b0, 1'b1, 1'b0);
        push(1'b0, 3, 1'b0, 1'b0, 1'b0, 1'b0);
        // Press bounce (1,1,1,0 then held), then release bounce (0,1,0 held).
        push(1'b1, 3, 1'b0, 1'b0, 1'b0, 1'b0);
        push(1'b0, 1, 1'b0, 1'b0, 1'b0, 1'b0);
        push(1'b1, 6, 1'b0, 1'b0, 1'b0, 1'b0);
        push(1'b1, 1, 1'b1, 1'b1, 1'b0, 1'b0);
        push(1'b1, 2, 1'b1, 1'b0, 1'b0, 1'b0);
        push(1'b0, 1, 1'b1, 1'b0, 1'b0, 1'b0);
        push(1'b1, 1, 1'b1, 1'b0, 1'b0, 1'b0);
        push(1'b0, 6, 1'b1, 1'b0, 1'b0, 1'b0);
        push(1'b0, 1, 1'b0, 1'b0, 1'b1, 1'b0);
        push(1'b0, 3, 1'b0, 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk) key = vecs[i].key;
            @(posedge clk);
            #1;
            check($sformatf("table[%0d]", i), pack_a(), vecs[i].exp);
        end

        // Auto-repeat while held.
        @(negedge clk) key = 1'b1;
        lat = -1;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk);
            #1;
            if (a_press) begin
                lat = c;
                break;
            end
        end
        check_int("rpt_press_latency", lat, 6);
        for (int k = 1; k <= 30; k++) begin
            @(posedge clk);
            #1;
            exp_rp = (k == 10) || ((k > 10) && (((k - 10) % 3) == 0));
            check($sformatf("rpt_hold[%0d]", k), pack_a(), {1'b1, 1'b0, 1'b0, exp_rp, exp_rp});
        end
        @(negedge clk) key = 1'b0;
        lat = -1;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk);
            #1;
            if (a_release) begin
                lat = c;
                break;
            end
        end
        check_int("rpt_release_latency", lat, 6);
        @(posedge clk);
        #1;
        check("rpt_after_release", pack_a(), 5'b00000);

        // Reset during PRESS_WAIT.
        @(negedge clk) key = 1'b1;
        repeat (4) @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        check("rst_pw_async", pack_a(), 5'b00000);
        key = 1'b0;
        @(negedge clk) reset_n = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            #1;
            check($sformatf("rst_pw_quiet[%0d]", c), pack_a(), 5'b00000);
        end

        // Reset during PRESSED: key_o must drop without waiting for a clock.
        @(negedge clk) key = 1'b1;
        lat = -1;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk);
            #1;
            if (a_press) begin
                lat = c;
                break;
            end
        end
        check_int("rst_hold_press_latency", lat, 6);
        repeat (2) @(posedge clk);
        #3;
        check("rst_hold_before", pack_a(), 5'b10000);
        reset_n = 1'b0;
        #1;
        check("rst_hold_async", pack_a(), 5'b00000);
        key = 1'b0;
        @(negedge clk) reset_n = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            #1;
            check($sformatf("rst_hold_quiet[%0d]", c), pack_a(), 5'b00000);
        end

        // Active-low pad, repeat disabled.
        @(negedge clk) key_al = 1'b0;
        for (int c = 0; c < 26; c++) begin
            @(posedge clk);
            #1;
            if (c == 6) begin
                check($sformatf("al_press[%0d]", c), pack_b(), 5'b11001);
            end else if (c > 6) begin
                check($sformatf("al_hold[%0d]", c), pack_b(), 5'b10000);
            end else begin
                check($sformatf("al_wait[%0d]", c), pack_b(), 5'b00000);
            end
        end
        @(negedge clk) key_al = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            #1;
            if (c == 6) begin
                check($sformatf("al_release[%0d]", c), pack_b(), 5'b00100);
            end else if (c < 6) begin
                check($sformatf("al_rwait[%0d]", c), pack_b(), 5'b10000);
            end else begin
                check($sformatf("al_idle[%0d]", c), pack_b(), 5'b00000);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
